// File: rtl/tile_lane_scheduler.sv
// tile_lane_scheduler
//
// Four-lane falling-tile tracker for a rhythm game. Each lane holds a small
// circular queue of tile Y positions. Spawn pulses push new tiles at Y=0,
// frame ticks move every tile down by `speed` (clamped at Y_MAX), and rising
// key edges are judged against the lowest tile (the queue head) in that lane.
// The block also owns the run state: IDLE -> RUN -> OVER -> RUN ...
//
// Ports
//   Clk, Reset        : clock and asynchronous active-high reset
//   start             : level; a rising edge starts a run from IDLE or OVER
//   frame_tick        : one-cycle pulse per video frame
//   spawn[3:0]        : per-lane spawn pulses (bit0 = lane 1)
//   key[3:0]          : per-lane key levels, already synchronous to Clk
//   speed[3:0]        : pixels added to each tile per frame tick
//   head_valid[3:0]   : lane queue non-empty
//   head_y            : head Y per lane, lane n at [n*Y_W +: Y_W], 0 if empty
//   lane_count        : occupancy per lane, lane n at [n*CW +: CW]
//   hit_pulse/miss_pulse : one-cycle per-lane judgement pulses
//   score, misses     : saturating totals
//   running, game_over: run state decode
//   overflow          : sticky, a spawn hit a full lane and was dropped
module tile_lane_scheduler #(
    parameter int DEPTH      = 4,
    parameter int Y_W        = 10,
    parameter int Y_MAX      = 479,
    parameter int HIT_LO     = 400,
    parameter int HIT_HI     = 479,
    parameter int MISS_LIMIT = 3,
    localparam int CW        = $clog2(DEPTH + 1),
    localparam int PW        = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              frame_tick,
    input  logic [3:0]        spawn,
    input  logic [3:0]        key,
    input  logic [3:0]        speed,
    output logic [3:0]        head_valid,
    output logic [4*Y_W-1:0]  head_y,
    output logic [4*CW-1:0]   lane_count,
    output logic [3:0]        hit_pulse,
    output logic [3:0]        miss_pulse,
    output logic [15:0]       score,
    output logic [7:0]        misses,
    output logic              running,
    output logic              game_over,
    output logic              overflow
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_OVER} state_t;

    localparam logic [Y_W-1:0] Y_MAX_C  = Y_W'(Y_MAX);
    localparam logic [Y_W-1:0] HIT_LO_C = Y_W'(HIT_LO);
    localparam logic [Y_W-1:0] HIT_HI_C = Y_W'(HIT_HI);
    localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
    localparam logic [7:0]     LIMIT_C  = 8'(MISS_LIMIT);

    state_t            state_q, state_d;
    logic [Y_W-1:0]    ybuf_q [4][DEPTH];
    logic [Y_W-1:0]    ybuf_d [4][DEPTH];
    logic [PW-1:0]     rd_q [4], rd_d [4];
    logic [PW-1:0]     wr_q [4], wr_d [4];
    logic [CW-1:0]     count_q [4], count_d [4];
    logic [3:0]        key_q, hit_q, hit_d, miss_q, miss_d;
    logic              start_q, overflow_q, overflow_d;
    logic [15:0]       score_q, score_d;
    logic [7:0]        misses_q, misses_d;

    logic              in_run, start_rise;
    logic [3:0]        key_rise;
    logic [3:0]        lane_valid, lane_hit, lane_miss, lane_pop, lane_push, lane_drop;
    logic [Y_W-1:0]    lane_y [4];
    logic [Y_W-1:0]    adv_y [4][DEPTH];
    logic [2:0]        n_hits, n_miss;
    logic [16:0]       score_sum;
    logic [8:0]        miss_sum;

    assign in_run     = (state_q == ST_RUN);
    assign start_rise = start & ~start_q;
    assign key_rise   = key & ~key_q;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic in_window, tick_miss, wrong_press;

        assign lane_valid[gi] = (count_q[gi] != '0);
        // Judgement uses the stored head, i.e. the position before this cycle's advance.
        assign lane_y[gi]     = ybuf_q[gi][rd_q[gi]];
        assign in_window      = (lane_y[gi] >= HIT_LO_C) && (lane_y[gi] <= HIT_HI_C);
        assign lane_hit[gi]   = in_run && key_rise[gi] && lane_valid[gi] && in_window;
        assign wrong_press    = in_run && key_rise[gi] && !lane_hit[gi];
        // A key hit on the bottom tile takes precedence over the frame-tick miss.
        assign tick_miss      = in_run && frame_tick && lane_valid[gi]
                                && (lane_y[gi] == Y_MAX_C) && !lane_hit[gi];
        assign lane_miss[gi]  = wrong_press | tick_miss;
        assign lane_pop[gi]   = lane_hit[gi] | tick_miss;
        // A pop in the same cycle frees a slot, so a full lane can still accept.
        assign lane_push[gi]  = in_run && spawn[gi] && ((count_q[gi] != DEPTH_C) || lane_pop[gi]);
        assign lane_drop[gi]  = in_run && spawn[gi] && !lane_push[gi];

        for (genvar ge = 0; ge < DEPTH; ge++) begin : g_entry
            logic [Y_W:0] sum;
            assign sum = {1'b0, ybuf_q[gi][ge]} + {{(Y_W - 3){1'b0}}, speed};
            assign adv_y[gi][ge] = (sum > {1'b0, Y_MAX_C}) ? Y_MAX_C : sum[Y_W-1:0];
        end

        assign head_valid[gi]           = lane_valid[gi];
        assign head_y[gi*Y_W +: Y_W]    = lane_valid[gi] ? lane_y[gi] : '0;
        assign lane_count[gi*CW +: CW]  = count_q[gi];
    end

    always_comb begin
        state_d    = state_q;
        ybuf_d     = ybuf_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        score_d    = score_q;
        misses_d   = misses_q;
        hit_d      = lane_hit;
        miss_d     = lane_miss;
        n_hits     = '0;
        n_miss     = '0;
        for (int l = 0; l < 4; l++) begin
            n_hits = n_hits + {2'b00, lane_hit[l]};
            n_miss = n_miss + {2'b00, lane_miss[l]};
        end
        score_sum  = {1'b0, score_q} + {14'd0, n_hits};
        miss_sum   = {1'b0, misses_q} + {6'd0, n_miss};

        if (in_run) begin
            for (int l = 0; l < 4; l++) begin
                if (frame_tick) begin
                    // Advancing the popped slot too is harmless; it is no longer read.
                    for (int e = 0; e < DEPTH; e++) ybuf_d[l][e] = adv_y[l][e];
                end
                if (lane_pop[l]) rd_d[l] = rd_q[l] + 1'b1;
                if (lane_push[l]) begin
                    ybuf_d[l][wr_q[l]] = '0;
                    wr_d[l] = wr_q[l] + 1'b1;
                end
                count_d[l] = count_q[l] - {{(CW-1){1'b0}}, lane_pop[l]}
                                        + {{(CW-1){1'b0}}, lane_push[l]};
            end
            if (|lane_drop) overflow_d = 1'b1;
            score_d  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
            misses_d = miss_sum[8] ? 8'hFF : miss_sum[7:0];
            if (misses_d >= LIMIT_C) state_d = ST_OVER;
        end else if (start_rise) begin
            state_d    = ST_RUN;
            overflow_d = 1'b0;
            score_d    = '0;
            misses_d   = '0;
            for (int l = 0; l < 4; l++) begin
                rd_d[l]    = '0;
                wr_d[l]    = '0;
                count_d[l] = '0;
                for (int e = 0; e < DEPTH; e++) ybuf_d[l][e] = '0;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            key_q      <= '0;
            start_q    <= 1'b0;
            hit_q      <= '0;
            miss_q     <= '0;
            overflow_q <= 1'b0;
            score_q    <= '0;
            misses_q   <= '0;
            for (int l = 0; l < 4; l++) begin
                rd_q[l]    <= '0;
                wr_q[l]    <= '0;
                count_q[l] <= '0;
                for (int e = 0; e < DEPTH; e++) ybuf_q[l][e] <= '0;
            end
        end else begin
            state_q    <= state_d;
            key_q      <= key;
            start_q    <= start;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            overflow_q <= overflow_d;
            score_q    <= score_d;
            misses_q   <= misses_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            count_q    <= count_d;
            ybuf_q     <= ybuf_d;
        end
    end

    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
    assign score      = score_q;
    assign misses     = misses_q;
    assign overflow   = overflow_q;
    assign running    = (state_q == ST_RUN);
    assign game_over  = (state_q == ST_OVER);

endmodule

// File: tb/tb_tile_lane_scheduler.sv
module tb_tile_lane_scheduler;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic        frame_tick = 1'b0;
    logic [3:0]  spawn = '0;
    logic [3:0]  key = '0;
    logic [3:0]  speed = 4'd8;
    logic [3:0]  head_valid;
    logic [39:0] head_y;
    logic [11:0] lane_count;
    logic [3:0]  hit_pulse, miss_pulse;
    logic [15:0] score;
    logic [7:0]  misses;
    logic        running, game_over, overflow;

    int checks = 0;
    int errors = 0;

    tile_lane_scheduler dut (
        .Clk(Clk), .Reset(Reset), .start(start), .frame_tick(frame_tick),
        .spawn(spawn), .key(key), .speed(speed),
        .head_valid(head_valid), .head_y(head_y), .lane_count(lane_count),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .score(score),
        .misses(misses), .running(running), .game_over(game_over),
        .overflow(overflow)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0]  sp;
        logic [3:0]  k;
        logic        ft;
        logic [3:0]  e_hit;
        logic [3:0]  e_miss;
        logic [11:0] e_cnt;
        logic [7:0]  e_misses;
        logic        e_over;
        logic        e_ovf;
    } vec_t;

    vec_t wrong_tab [8];
    vec_t ovf_tab [5];

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // One clock: apply inputs, step past the edge, clear the pulse inputs.
    task automatic tick(input logic [3:0] sp, input logic [3:0] k, input logic ft);
        spawn = sp;
        key = k;
        frame_tick = ft;
        @(posedge Clk);
        #1;
        spawn = '0;
        frame_tick = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) tick(4'b0000, 4'b0000, 1'b1);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(4'b0000, 4'b0000, 1'b0);
        start = 1'b0;
        chk("start_running", {39'd0, running}, 40'd1);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #2;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        tick(v.sp, v.k, v.ft);
        chk({tag, "_hit"},    {36'd0, hit_pulse},  {36'd0, v.e_hit});
        chk({tag, "_miss"},   {36'd0, miss_pulse}, {36'd0, v.e_miss});
        chk({tag, "_count"},  {28'd0, lane_count}, {28'd0, v.e_cnt});
        chk({tag, "_misses"}, {32'd0, misses},     {32'd0, v.e_misses});
        chk({tag, "_over"},   {39'd0, game_over},  {39'd0, v.e_over});
        chk({tag, "_ovf"},    {39'd0, overflow},   {39'd0, v.e_ovf});
    endtask

    initial begin
        //            sp       k        ft    hit      miss     cnt     misses over ovf
        wrong_tab[0] = '{4'b0000, 4'b0010, 1'b0, 4'b0000, 4'b0010, 12'h000, 8'd1, 1'b0, 1'b0};
        wrong_tab[1] = '{4'b0000, 4'b0010, 1'b0, 4'b0000, 4'b0000, 12'h000, 8'd1, 1'b0, 1'b0};
        wrong_tab[2] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 12'h000, 8'd1, 1'b0, 1'b0};
        wrong_tab[3] = '{4'b0000, 4'b0010, 1'b0, 4'b0000, 4'b0010, 12'h000, 8'd2, 1'b0, 1'b0};
        wrong_tab[4] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 12'h000, 8'd2, 1'b0, 1'b0};
        wrong_tab[5] = '{4'b0000, 4'b0010, 1'b0, 4'b0000, 4'b0010, 12'h000, 8'd3, 1'b1, 1'b0};
        wrong_tab[6] = '{4'b1000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 12'h000, 8'd3, 1'b1, 1'b0};
        wrong_tab[7] = '{4'b0000, 4'b0100, 1'b1, 4'b0000, 4'b0000, 12'h000, 8'd3, 1'b1, 1'b0};
        // lane 4 occupancy lives in lane_count[11:9]
        ovf_tab[0] = '{4'b1000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 12'h200, 8'd0, 1'b0, 1'b0};
        ovf_tab[1] = '{4'b1000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 12'h400, 8'd0, 1'b0, 1'b0};
        ovf_tab[2] = '{4'b1000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 12'h600, 8'd0, 1'b0, 1'b0};
        ovf_tab[3] = '{4'b1000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 12'h800, 8'd0, 1'b0, 1'b0};
        ovf_tab[4] = '{4'b1000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 12'h800, 8'd0, 1'b0, 1'b1};

        // Reset state
        #1;
        chk("rst_running", {39'd0, running}, 40'd0);
        chk("rst_over", {39'd0, game_over}, 40'd0);
        chk("rst_head_valid", {36'd0, head_valid}, 40'd0);
        chk("rst_score", {24'd0, score}, 40'd0);
        @(negedge Clk);
        Reset = 1'b0;
        tick(4'b0001, 4'b0000, 1'b1);
        chk("idle_ignores_spawn", {28'd0, lane_count}, 40'd0);
        do_start();

        // Lane 1: spawn, fall to the bottom, then miss
        tick(4'b0001, 4'b0000, 1'b0);
        chk("a_head_valid", {36'd0, head_valid}, 40'd1);
        chk("a_head_y0", {30'd0, head_y[9:0]}, 40'd0);
        frames(1);
        chk("a_head_y8", {30'd0, head_y[9:0]}, 40'd8);
        frames(59);
        chk("a_head_y479", {30'd0, head_y[9:0]}, 40'd479);
        chk("a_no_early_miss", {36'd0, miss_pulse}, 40'd0);
        frames(1);
        chk("a_miss_pulse", {36'd0, miss_pulse}, 40'd1);
        chk("a_misses", {32'd0, misses}, 40'd1);
        chk("a_count", {28'd0, lane_count}, 40'd0);
        tick(4'b0000, 4'b0000, 1'b0);
        chk("a_miss_one_cycle", {36'd0, miss_pulse}, 40'd0);

        // Lane 3: hit at Y=400, held key gives no second judgement
        tick(4'b0100, 4'b0000, 1'b0);
        frames(50);
        chk("b_head_y400", {30'd0, head_y[29:20]}, 40'd400);
        tick(4'b0000, 4'b0100, 1'b0);
        chk("b_hit_pulse", {36'd0, hit_pulse}, 40'd4);
        chk("b_score", {24'd0, score}, 40'd1);
        chk("b_head_valid", {36'd0, head_valid}, 40'd0);
        tick(4'b0000, 4'b0100, 1'b0);
        chk("b_held_no_hit", {36'd0, hit_pulse}, 40'd0);
        chk("b_held_no_miss", {36'd0, miss_pulse}, 40'd0);
        chk("b_misses_same", {32'd0, misses}, 40'd1);

        // Wrong presses on empty lane 2 until game over
        do_reset();
        do_start();
        foreach (wrong_tab[i]) run_vec($sformatf("c%0d", i), wrong_tab[i]);
        chk("c_not_running", {39'd0, running}, 40'd0);

        // Restart from OVER, overflow on lane 4
        do_start();
        chk("d_misses_cleared", {32'd0, misses}, 40'd0);
        foreach (ovf_tab[i]) run_vec($sformatf("d%0d", i), ovf_tab[i]);
        frames(50);
        chk("d_head_y400", {30'd0, head_y[39:30]}, 40'd400);
        tick(4'b1000, 4'b1000, 1'b0);
        chk("d_hit_pulse", {36'd0, hit_pulse}, 40'd8);
        chk("d_count_full", {28'd0, lane_count}, 40'h800);
        chk("d_score", {24'd0, score}, 40'd1);
        chk("d_next_head", {30'd0, head_y[39:30]}, 40'd400);

        // Head at 479: key rise and frame tick together count once, as a hit
        frames(10);
        chk("e_head_y479", {30'd0, head_y[39:30]}, 40'd479);
        tick(4'b0000, 4'b1000, 1'b1);
        chk("e_hit_pulse", {36'd0, hit_pulse}, 40'd8);
        chk("e_no_miss", {36'd0, miss_pulse}, 40'd0);
        chk("e_score", {24'd0, score}, 40'd2);
        chk("e_misses", {32'd0, misses}, 40'd0);
        chk("e_count", {28'd0, lane_count}, 40'h600);
        tick(4'b0000, 4'b0000, 1'b1);
        chk("e_tick_miss", {36'd0, miss_pulse}, 40'd8);
        chk("e_misses1", {32'd0, misses}, 40'd1);
        chk("e_count2", {28'd0, lane_count}, 40'h400);

        // Multi-lane hits in one cycle, then async reset mid-run
        do_reset();
        do_start();
        tick(4'b1111, 4'b0000, 1'b0);
        frames(50);
        tick(4'b0000, 4'b1111, 1'b0);
        chk("f_hit_all", {36'd0, hit_pulse}, 40'd15);
        chk("f_score4", {24'd0, score}, 40'd4);
        tick(4'b0001, 4'b0000, 1'b0);
        frames(50);
        tick(4'b0000, 4'b0001, 1'b0);
        chk("f_score5", {24'd0, score}, 40'd5);
        chk("f_running", {39'd0, running}, 40'd1);
        Reset = 1'b1;
        #1;
        chk("g_async_score", {24'd0, score}, 40'd0);
        chk("g_async_running", {39'd0, running}, 40'd0);
        chk("g_async_hit", {36'd0, hit_pulse}, 40'd0);
        chk("g_async_over", {39'd0, game_over}, 40'd0);
        @(negedge Clk);
        Reset = 1'b0;
        do_start();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
